// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2: streaming 2x2 stride-2 max-pool for a raster-order signed
// sample stream. A half-row line buffer holds the horizontal pair maxima from
// each even row, and the odd row merges them into one pooled output per window.
// Optional feature: define RELU_MAXPOOL_RELU_EN to clamp negative samples to
// zero before pooling. When it is undefined, no ReLU logic is built.
module relu_maxpool2x2 #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 26,
    parameter int IMG_H  = 26
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     rdata_r,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     wdata_r,
    output logic                     frame_done
);
    localparam int PW  = IMG_W / 2;
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int LBW = (PW > 1) ? $clog2(PW) : 1;

    // Row parity is the only control state.
    typedef enum logic {EVEN_ROW = 1'b0, ODD_ROW = 1'b1} row_par_e;

    row_par_e                 state_q, state_d;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic signed [DATA_W-1:0] h_reg_q;
    logic signed [DATA_W-1:0] linebuf [PW];

    logic signed [DATA_W-1:0] x_r;
    logic signed [DATA_W-1:0] hmax;
    logic signed [DATA_W-1:0] lb_rd;
    logic signed [DATA_W-1:0] vmax;
    logic [LBW-1:0]           lb_idx;
    logic                     col_last;
    logic                     row_last;
    logic                     col_odd;

    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign col_odd  = col_q[0];
    assign lb_idx   = LBW'(col_q >> 1);

`ifdef RELU_MAXPOOL_RELU_EN
    assign x_r = data_in[DATA_W-1] ? '0 : data_in;
`else
    assign x_r = data_in;
`endif

    // Horizontal pair max, then vertical merge with the stored even-row pair.
    assign hmax  = (h_reg_q > x_r) ? h_reg_q : x_r;
    assign lb_rd = linebuf[lb_idx];
    assign vmax  = (lb_rd > hmax) ? lb_rd : hmax;

    // Next-state for position counters and row parity. The parity is forced
    // back to EVEN at frame wrap, so odd IMG_H frames restart correctly.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (rdata_r) begin
            if (col_last) begin
                col_d = '0;
                if (row_last) begin
                    row_d   = '0;
                    state_d = EVEN_ROW;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Counters, horizontal holding register and the registered output pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EVEN_ROW;
            col_q      <= '0;
            row_q      <= '0;
            h_reg_q    <= '0;
            data_out   <= '0;
            wdata_r    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wdata_r    <= 1'b0;
            frame_done <= 1'b0;
            if (rdata_r) begin
                if (!col_odd) begin
                    h_reg_q <= x_r;
                end else if (state_q == ODD_ROW) begin
                    data_out <= vmax;
                    wdata_r  <= 1'b1;
                end
                frame_done <= col_last && row_last;
            end
        end
    end

    // Line buffer is not reset. Every entry is rewritten on an even row
    // before the following odd row reads it.
    always_ff @(posedge clk) begin
        if (rdata_r && col_odd && (state_q == EVEN_ROW)) begin
            linebuf[lb_idx] <= hmax;
        end
    end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Bench for relu_maxpool2x2. It uses three instances (4x4, 5x5, 26x26).
// The frame-array model predicts every pooled pulse and frame_done pulse
// with its due cycle. A literal table pins the model's results.
module tb_relu_maxpool2x2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [31:0] din [3];
  logic [2:0]         vin;
  logic signed [31:0] dout [3];
  logic [2:0]         wv;
  logic [2:0]         fd;

  relu_maxpool2x2 #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .reset_n(reset_n), .data_in(din[0]), .rdata_r(vin[0]),
    .data_out(dout[0]), .wdata_r(wv[0]), .frame_done(fd[0]));
  relu_maxpool2x2 #(.DATA_W(32), .IMG_W(5), .IMG_H(5)) u5 (
    .clk(clk), .reset_n(reset_n), .data_in(din[1]), .rdata_r(vin[1]),
    .data_out(dout[1]), .wdata_r(wv[1]), .frame_done(fd[1]));
  relu_maxpool2x2 #(.DATA_W(32), .IMG_W(26), .IMG_H(26)) u26 (
    .clk(clk), .reset_n(reset_n), .data_in(din[2]), .rdata_r(vin[2]),
    .data_out(dout[2]), .wdata_r(wv[2]), .frame_done(fd[2]));

  typedef struct {
    int     val;
    longint due;
  } exp_t;

  exp_t   qd [3][$];
  longint qf [3][$];
  int     obs [3][$];
  int     fdn [3];
  int     WD [3] = '{4, 5, 26};
  int     HT [3] = '{4, 5, 26};
  int     pix [3][26][26];
  int     pr [3];
  int     pc [3];
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int relu(input int x);
`ifdef RELU_MAXPOOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Drive one sample into instance i after `gap` idle cycles, and update the model.
  task automatic send(input int i, input int val, input int gap);
    int   r, c, x;
    exp_t e;
    repeat (gap) begin
      @(posedge clk); #1;
      vin = '0;
    end
    @(posedge clk); #1;
    vin = '0;
    vin[i] = 1'b1;
    din[i] = val;
    r = pr[i];
    c = pc[i];
    x = relu(val);
    pix[i][r][c] = x;
    if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (HT[i] / 2)) && (c < 2 * (WD[i] / 2))) begin
      e.val = max2(max2(pix[i][r-1][c-1], pix[i][r-1][c]), max2(pix[i][r][c-1], pix[i][r][c]));
      e.due = cyc + 1;
      qd[i].push_back(e);
    end
    if ((r == HT[i] - 1) && (c == WD[i] - 1)) qf[i].push_back(cyc + 1);
    if (c == WD[i] - 1) begin
      pc[i] = 0;
      pr[i] = (r == HT[i] - 1) ? 0 : r + 1;
    end else begin
      pc[i] = c + 1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vin = '0;
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 3; i++) begin
      obs[i].delete();
      fdn[i] = 0;
    end
  endtask

  // Reset all instances, then check that the reset values appear on every output.
  task automatic do_reset();
    @(posedge clk); #1;
    vin = '0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pr[i] = 0;
      pc[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset data_out u%0d", i), dout[i], 0);
      chk($sformatf("reset wdata_r u%0d", i), wv[i], 0);
      chk($sformatf("reset frame_done u%0d", i), fd[i], 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Compare DUT pulses against the model queues on every cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (qd[i].size() != 0 && qd[i][0].due < cyc) begin
        chk($sformatf("missing pulse u%0d", i), 0, 1);
        void'(qd[i].pop_front());
      end
      if (qf[i].size() != 0 && qf[i][0] < cyc) begin
        chk($sformatf("missing frame_done u%0d", i), 0, 1);
        void'(qf[i].pop_front());
      end
      if (wv[i]) begin
        obs[i].push_back(dout[i]);
        if (qd[i].size() == 0) begin
          chk($sformatf("spurious pulse u%0d", i), 1, 0);
        end else begin
          exp_t e;
          e = qd[i].pop_front();
          chk($sformatf("data_out u%0d", i), dout[i], e.val);
          chk($sformatf("pulse cycle u%0d", i), cyc, e.due);
        end
      end
      if (fd[i]) begin
        fdn[i]++;
        if (qf[i].size() == 0) begin
          chk($sformatf("spurious frame_done u%0d", i), 1, 0);
        end else begin
          chk($sformatf("frame_done cycle u%0d", i), cyc, qf[i].pop_front());
        end
      end
    end
  end

  initial begin
    int neg;
    vin = '0;
    for (int i = 0; i < 3; i++) begin
      din[i] = 0;
      pr[i] = 0;
      pc[i] = 0;
      fdn[i] = 0;
    end
    do_reset();

    // T1: 4x4 frame with ramp 0..15 and continuous valid.
    clear_obs();
    for (int v = 0; v < 16; v++) send(0, v, 0);
    idle(3);
    chk("t1 count", obs[0].size(), 4);
    chk("t1 out0", obs[0][0], 5);
    chk("t1 out1", obs[0][1], 7);
    chk("t1 out2", obs[0][2], 13);
    chk("t1 out3", obs[0][3], 15);
    chk("t1 frame_done", fdn[0], 1);

    // T2: all -9, so the result depends on whether ReLU is enabled.
`ifdef RELU_MAXPOOL_RELU_EN
    neg = 0;
`else
    neg = -9;
`endif
    clear_obs();
    for (int v = 0; v < 16; v++) send(0, -9, 0);
    idle(3);
    chk("t2 count", obs[0].size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t2 out%0d", k), obs[0][k], neg);

    // T3: ramp with random 0..3 cycle bubbles before each sample.
    clear_obs();
    for (int v = 0; v < 16; v++) send(0, v, $urandom_range(0, 3));
    idle(3);
    chk("t3 count", obs[0].size(), 4);
    chk("t3 out0", obs[0][0], 5);
    chk("t3 out1", obs[0][1], 7);
    chk("t3 out2", obs[0][2], 13);
    chk("t3 out3", obs[0][3], 15);

    // T4: reset after 10 samples. Windows already completed (5, 7) have
    // emitted; the partially filled row pair must produce nothing. The
    // next frame then starts from pixel (0,0).
    clear_obs();
    for (int v = 0; v < 10; v++) send(0, v, 0);
    idle(2);
    do_reset();
    for (int v = 0; v < 16; v++) send(0, v, 0);
    idle(3);
    chk("t4 count", obs[0].size(), 6);
    chk("t4 out2", obs[0][2], 5);
    chk("t4 out3", obs[0][3], 7);
    chk("t4 out4", obs[0][4], 13);
    chk("t4 out5", obs[0][5], 15);
    chk("t4 frame_done", fdn[0], 1);

    // T5: two back-to-back 26x26 frames with input row*26+col.
    clear_obs();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 26; r++)
        for (int c = 0; c < 26; c++) send(2, r * 26 + c, 0);
    idle(3);
    chk("t5 count", obs[2].size(), 338);
    chk("t5 first", obs[2][0], 27);
    chk("t5 last f0", obs[2][168], 675);
    chk("t5 first f1", obs[2][169], 27);
    chk("t5 last f1", obs[2][337], 675);
    chk("t5 frame_done", fdn[2], 2);

    // T6: 5x5 frame, where the last column and the last row are dropped.
    clear_obs();
    for (int v = 0; v < 25; v++) send(1, v, 0);
    idle(3);
    chk("t6 count", obs[1].size(), 4);
    chk("t6 out0", obs[1][0], 6);
    chk("t6 out1", obs[1][1], 8);
    chk("t6 out2", obs[1][2], 16);
    chk("t6 out3", obs[1][3], 18);
    chk("t6 frame_done", fdn[1], 1);

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pending pulses u%0d", i), qd[i].size(), 0);
      chk($sformatf("pending frame_done u%0d", i), qf[i].size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
